// File: rtl/alu_share_arbiter.sv
// Two-requester front end for the shared 8-bit ALU: grants one op at a time, result in 2 cycles (3 for a wide multiply).
// Requests are accepted only in IDLE; responses are a single-cycle strobe and cannot be stalled.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req0_unit,
  input  logic [2:0]  req1_unit,
  input  logic        req0_op,
  input  logic        req1_op,
  input  logic        req0_wide,
  input  logic        req1_wide,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [2:0]  alu_unit_sel,
  output logic        alu_op_sel,
  output logic        alu_mul_seg_sel,
  output logic [7:0]  alu_acc,
  output logic [7:0]  alu_src,
  input  logic [7:0]  alu_res
);

  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

  state_t      state, state_nxt;
  logic        ptr;
  logic        owner;
  logic        win;
  logic        take;
  logic [1:0]  grant;
  logic [2:0]  unit_q;
  logic        op_q;
  logic        wide_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  lo_q;
  logic [7:0]  lo_val;
  logic        wide_mul;

  assign wide_mul = wide_q && (unit_q == 3'b001);
  // Compare only writes bit 0 of the ALU result; the rest is stale.
  assign lo_val   = (unit_q == 3'b101) ? {7'b0, alu_res[0]} : alu_res;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win       = 1'b0;
    grant     = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          take      = 1'b1;
          if (&req_valid) win = RR_EN ? ptr : 1'b0;
          else            win = req_valid[1];
          grant     = win ? 2'b10 : 2'b01;
          state_nxt = EXEC_LO;
        end
      end
      EXEC_LO: state_nxt = wide_mul ? EXEC_HI : RESP;
      EXEC_HI: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Keep the accept strobe low while reset is held, even with requests pending.
  assign req_ready       = grant & {2{rst_n}};
  assign rsp_valid       = (state == RESP);
  assign busy            = (state != IDLE);
  assign alu_unit_sel    = (state == IDLE) ? 3'b011 : unit_q;
  assign alu_op_sel      = (state != IDLE) && op_q;
  assign alu_mul_seg_sel = (state == EXEC_HI);
  assign alu_acc         = (state == IDLE) ? 8'h00 : a_q;
  assign alu_src         = (state == IDLE) ? 8'h00 : b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      unit_q   <= 3'b011;
      op_q     <= 1'b0;
      wide_q   <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      lo_q     <= 8'h00;
      rsp_id   <= 1'b0;
      rsp_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner  <= win;
        ptr    <= ~win;
        unit_q <= win ? req1_unit : req0_unit;
        op_q   <= win ? req1_op   : req0_op;
        wide_q <= win ? req1_wide : req0_wide;
        a_q    <= win ? req1_a    : req0_a;
        b_q    <= win ? req1_b    : req0_b;
      end
      // The response registers change only on entry to RESP so they hold between responses.
      if (state == EXEC_LO) begin
        lo_q <= lo_val;
        if (!wide_mul) begin
          rsp_data <= {8'h00, lo_val};
          rsp_id   <= owner;
        end
      end
      if (state == EXEC_HI) begin
        rsp_data <= {alu_res, lo_q};
        rsp_id   <= owner;
      end
    end
  end

endmodule
